// File: rtl/systolic_array_pkg.sv
// rtl/systolic_array_pkg.sv - shared defaults, FSM state codes and read-tag codes
package systolic_array_pkg;

   localparam int N_DEF       = 4;
   localparam int DW_DEF      = 16;
   localparam int AW_DEF      = 10;
   localparam int MAX_OUT_DEF = 4;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_WAIT_DRAIN = 3'd1;
   localparam state_t ST_WAIT_SPACE = 3'd2;
   localparam state_t ST_LOAD_W     = 3'd3;
   localparam state_t ST_LOAD_IP    = 3'd4;

   // Tag carried alongside each scratchpad read so the returning row can be routed.
   typedef logic [1:0] rd_kind_t;
   localparam rd_kind_t RD_NONE = 2'd0;
   localparam rd_kind_t RD_W    = 2'd1;
   localparam rd_kind_t RD_I    = 2'd2;
   localparam rd_kind_t RD_P    = 2'd3;

endpackage

// File: rtl/systolic_array_job_tracker.sv
// rtl/systolic_array_job_tracker.sv - outstanding-job counter and job_done pulse
module systolic_array_job_tracker
   import systolic_array_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int MAX_OUT = MAX_OUT_DEF
)(
   input  logic                         clk,
   input  logic                         nRST,
   input  logic                         accept,
   input  logic                         out_en,
   input  logic [$clog2(N)-1:0]         row_out,
   output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
   output logic                         job_done
);

   localparam int RW = $clog2(N);
   localparam int OW = $clog2(MAX_OUT + 1);

   logic dec;

   // A completion with nothing outstanding is ignored so the count cannot wrap.
   assign dec = out_en && (row_out == RW'(N - 1)) && (outstanding != '0);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         outstanding <= '0;
         job_done    <= 1'b0;
      end else begin
         job_done <= dec;
         if (accept && !dec)
            outstanding <= outstanding + OW'(1);
         else if (dec && !accept)
            outstanding <= outstanding - OW'(1);
      end
   end

endmodule

// File: rtl/systolic_array_load_sequencer.sv
// rtl/systolic_array_load_sequencer.sv - sequences scratchpad reads into systolic-array weight/input/partial loads
module systolic_array_load_sequencer
   import systolic_array_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int DW      = DW_DEF,
   parameter int AW      = AW_DEF,
   parameter int MAX_OUT = MAX_OUT_DEF
)(
   input  logic                 clk,
   input  logic                 nRST,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic                 job_wload,
   input  logic [AW-1:0]        job_base,
   output logic                 sp_ren,
   output logic [AW-1:0]        sp_addr,
   input  logic [N*DW-1:0]      sp_rdata,
   output logic                 weight_en,
   output logic                 input_en,
   output logic                 partial_en,
   output logic [$clog2(N)-1:0] row_in_en,
   output logic [$clog2(N)-1:0] row_ps_en,
   output logic [N*DW-1:0]      array_in,
   output logic [N*DW-1:0]      array_in_partials,
   input  logic                 drained,
   input  logic                 fifo_has_space,
   input  logic                 out_en,
   input  logic [$clog2(N)-1:0] row_out,
   output logic                 busy,
   output logic                 job_done
);

   localparam int RW = $clog2(N);
   localparam int CW = $clog2(N + 1);
   localparam int OW = $clog2(MAX_OUT + 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             ph;
   logic [AW-1:0]    base_q;
   logic             rdy_ok;
   rd_kind_t         kind0;
   rd_kind_t         kind1;
   logic [RW-1:0]    row0;
   logic [RW-1:0]    row1;
   logic [N*DW-1:0]  in_buf;
   logic [OW-1:0]    outstanding;
   logic             accept;
   logic             last_strobe;

   assign job_ready   = rdy_ok && (state == ST_IDLE) && (outstanding < OW'(MAX_OUT));
   assign accept      = job_valid && job_ready;
   assign busy        = (state != ST_IDLE) || (outstanding != '0);
   assign last_strobe = input_en && (row_in_en == RW'(N - 1));

   // Read issue: sp_ren/sp_addr and the routing tag are registered together.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         ph      <= 1'b0;
         base_q  <= '0;
         rdy_ok  <= 1'b0;
         sp_ren  <= 1'b0;
         sp_addr <= '0;
         kind0   <= RD_NONE;
         row0    <= '0;
      end else begin
         rdy_ok  <= 1'b1;
         sp_ren  <= 1'b0;
         sp_addr <= '0;
         kind0   <= RD_NONE;
         row0    <= '0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  base_q <= job_base;
                  state  <= job_wload ? ST_WAIT_DRAIN : ST_WAIT_SPACE;
               end
            end
            ST_WAIT_DRAIN: begin
               if (drained) begin
                  state <= ST_LOAD_W;
                  cnt   <= '0;
               end
            end
            ST_WAIT_SPACE: begin
               if (fifo_has_space) begin
                  state <= ST_LOAD_IP;
                  cnt   <= '0;
                  ph    <= 1'b0;
               end
            end
            ST_LOAD_W: begin
               sp_ren  <= 1'b1;
               sp_addr <= base_q + AW'(cnt);
               kind0   <= RD_W;
               row0    <= RW'(cnt);
               if (cnt == CW'(N - 1)) begin
                  state <= ST_LOAD_IP;
                  cnt   <= '0;
                  ph    <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_LOAD_IP: begin
               // Input then partial for each row on back-to-back cycles.
               if (cnt != CW'(N)) begin
                  sp_ren <= 1'b1;
                  row0   <= RW'(cnt);
                  ph     <= ~ph;
                  if (!ph) begin
                     sp_addr <= base_q + AW'(N) + AW'(cnt);
                     kind0   <= RD_I;
                  end else begin
                     sp_addr <= base_q + AW'(2 * N) + AW'(cnt);
                     kind0   <= RD_P;
                     cnt     <= cnt + CW'(1);
                  end
               end
               if (last_strobe)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Returned data is valid one cycle after sp_ren; strobes register it a cycle later.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         kind1             <= RD_NONE;
         row1              <= '0;
         in_buf            <= '0;
         weight_en         <= 1'b0;
         input_en          <= 1'b0;
         partial_en        <= 1'b0;
         row_in_en         <= '0;
         row_ps_en         <= '0;
         array_in          <= '0;
         array_in_partials <= '0;
      end else begin
         kind1             <= kind0;
         row1              <= row0;
         weight_en         <= 1'b0;
         input_en          <= 1'b0;
         partial_en        <= 1'b0;
         row_in_en         <= '0;
         row_ps_en         <= '0;
         array_in          <= '0;
         array_in_partials <= '0;
         case (kind1)
            RD_W: begin
               weight_en <= 1'b1;
               row_in_en <= row1;
               array_in  <= sp_rdata;
            end
            RD_I: in_buf <= sp_rdata;
            RD_P: begin
               input_en          <= 1'b1;
               partial_en        <= 1'b1;
               row_in_en         <= row1;
               row_ps_en         <= row1;
               array_in          <= in_buf;
               array_in_partials <= sp_rdata;
            end
            default: ;
         endcase
      end
   end

   systolic_array_job_tracker #(
      .N       (N),
      .MAX_OUT (MAX_OUT)
   ) u_tracker (
      .clk         (clk),
      .nRST        (nRST),
      .accept      (accept),
      .out_en      (out_en),
      .row_out     (row_out),
      .outstanding (outstanding),
      .job_done    (job_done)
   );

endmodule

// File: tb/tb_systolic_array_load_sequencer.sv
// tb/tb_systolic_array_load_sequencer.sv - directed self-checking bench for the load sequencer
module tb_systolic_array_load_sequencer;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          nRST = 1'b1;
   logic          job_valid = 1'b0, job_wload = 1'b0;
   logic [AW-1:0] job_base = '0;
   logic          job_ready, sp_ren;
   logic [AW-1:0] sp_addr;
   logic [63:0]   sp_rdata = '0;
   logic          weight_en, input_en, partial_en;
   logic [1:0]    row_in_en, row_ps_en;
   logic [63:0]   array_in, array_in_partials;
   logic          drained = 1'b0, fifo_has_space = 1'b0, out_en = 1'b0;
   logic [1:0]    row_out = '0;
   logic          busy, job_done;

   int n_assert = 0;
   int n_fail   = 0;

   int          w_cnt, ip_cnt, ren_cnt, first_ren, zero_err, overlap_err, pair_err;
   bit          done_seen;
   logic [1:0]  w_row [8];
   logic [63:0] w_dat [8];
   int          w_cyc [8];
   logic [1:0]  ip_row [8];
   logic [1:0]  ip_prow [8];
   logic [63:0] ip_in [8];
   logic [63:0] ip_ps [8];
   int          ip_cyc [8];
   logic [AW-1:0] ren_addr [64];

   systolic_array_load_sequencer #(.N(N), .DW(DW), .AW(AW), .MAX_OUT(4)) dut (
      .clk(clk), .nRST(nRST), .job_valid(job_valid), .job_ready(job_ready),
      .job_wload(job_wload), .job_base(job_base), .sp_ren(sp_ren), .sp_addr(sp_addr),
      .sp_rdata(sp_rdata), .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
      .row_in_en(row_in_en), .row_ps_en(row_ps_en), .array_in(array_in),
      .array_in_partials(array_in_partials), .drained(drained), .fifo_has_space(fifo_has_space),
      .out_en(out_en), .row_out(row_out), .busy(busy), .job_done(job_done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] row_pat(input int a);
      logic [63:0] r;
      for (int j = 0; j < 4; j++) r[j*16 +: 16] = 16'(a * 16 + j + 'h1000);
      return r;
   endfunction

   // Scratchpad: data valid exactly one cycle after sp_ren, garbage otherwise.
   always @(posedge clk) sp_rdata <= sp_ren ? row_pat(int'(sp_addr)) : {4{16'hDEAD}};

   task automatic do_reset();
      nRST = 1'b0; job_valid = 0; job_wload = 0; job_base = '0;
      drained = 0; fifo_has_space = 0; out_en = 0; row_out = '0;
      repeat (2) @(negedge clk);
      nRST = 1'b1;
      @(negedge clk);
   endtask

   task automatic submit(input logic wl, input logic [AW-1:0] b, output bit ok);
      ok = 0; job_valid = 1; job_wload = wl; job_base = b;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (job_ready) ok = 1;
         @(negedge clk);
      end
      job_valid = 0;
   endtask

   task automatic collect(input int budget);
      int done_c;
      done_c = -1; w_cnt = 0; ip_cnt = 0; ren_cnt = 0; first_ren = -1;
      zero_err = 0; overlap_err = 0; pair_err = 0;
      for (int i = 0; i < 8; i++) begin
         w_row[i] = '0; w_dat[i] = '0; w_cyc[i] = 0;
         ip_row[i] = '0; ip_prow[i] = '0; ip_in[i] = '0; ip_ps[i] = '0; ip_cyc[i] = 0;
      end
      for (int i = 0; i < 64; i++) ren_addr[i] = '1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (sp_ren) begin
            ren_addr[c] = sp_addr;
            ren_cnt++;
            if (first_ren < 0) first_ren = c;
         end
         if (weight_en && (input_en || partial_en)) overlap_err++;
         if (input_en !== partial_en) pair_err++;
         if (weight_en) begin
            if (w_cnt < 8) begin w_row[w_cnt] = row_in_en; w_dat[w_cnt] = array_in; w_cyc[w_cnt] = c; end
            w_cnt++;
         end
         if (input_en) begin
            if (ip_cnt < 8) begin
               ip_row[ip_cnt] = row_in_en; ip_prow[ip_cnt] = row_ps_en;
               ip_in[ip_cnt] = array_in; ip_ps[ip_cnt] = array_in_partials; ip_cyc[ip_cnt] = c;
            end
            ip_cnt++;
            if (row_in_en == 2'd3) done_c = c;
         end
         if (!weight_en && !input_en && !partial_en &&
             (row_in_en != 0 || row_ps_en != 0 || array_in != 0 || array_in_partials != 0)) zero_err++;
         if (done_c >= 0 && c >= done_c + 3) break;
      end
      done_seen = (done_c >= 0);
   endtask

   task automatic test_reset();
      nRST = 1'b1; #2; nRST = 1'b0;
      @(negedge clk);
      n_assert++; if ({job_ready, busy, sp_ren, weight_en, input_en, partial_en, job_done} !== 7'd0) begin
         n_fail++; $display("FAIL reset_flags: got %b, expected 0000000", {job_ready, busy, sp_ren, weight_en, input_en, partial_en, job_done}); end
      n_assert++; if ({sp_addr, row_in_en, row_ps_en} !== '0 || array_in !== '0 || array_in_partials !== '0) begin
         n_fail++; $display("FAIL reset_data: got addr %0h in %0h ps %0h, expected 0", sp_addr, array_in, array_in_partials); end
      @(negedge clk);
      nRST = 1'b1; #1;
      n_assert++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL ready_at_release: got %b, expected 0", job_ready); end
      @(negedge clk);
      n_assert++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_clock: got %b, expected 1", job_ready); end
   endtask

   task automatic test_weight_load();
      bit ok;
      int k;
      do_reset(); drained = 1; fifo_has_space = 1;
      submit(1'b1, 10'd0, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL wl_accept: got 0, expected 1"); end
      collect(40);
      n_assert++; if (!done_seen) begin n_fail++; $display("FAIL wl_done: got 0, expected 1"); end
      n_assert++; if (w_cnt != 4) begin n_fail++; $display("FAIL wl_wcount: got %0d, expected 4", w_cnt); end
      n_assert++; if (first_ren != 1) begin n_fail++; $display("FAIL wl_first_ren: got %0d, expected 1", first_ren); end
      for (int r = 0; r < 4; r++) begin
         n_assert++; if (w_row[r] !== 2'(r) || w_dat[r] !== row_pat(r) || w_cyc[r] != 3 + r) begin
            n_fail++; $display("FAIL wl_wrow%0d: got row %0d data %0h cyc %0d, expected row %0d data %0h cyc %0d",
                               r, w_row[r], w_dat[r], w_cyc[r], r, row_pat(r), 3 + r); end
         k = (w_cyc[r] >= 2) ? w_cyc[r] - 2 : 0;
         n_assert++; if (ren_addr[k] !== AW'(r)) begin n_fail++; $display("FAIL wl_waddr%0d: got %0h, expected %0h", r, ren_addr[k], r); end
      end
      n_assert++; if (ip_cnt != 4) begin n_fail++; $display("FAIL wl_ipcount: got %0d, expected 4", ip_cnt); end
      for (int r = 0; r < 4; r++) begin
         n_assert++; if (ip_row[r] !== 2'(r) || ip_prow[r] !== 2'(r) || ip_cyc[r] != 8 + 2 * r) begin
            n_fail++; $display("FAIL wl_iprow%0d: got row %0d/%0d cyc %0d, expected row %0d cyc %0d",
                               r, ip_row[r], ip_prow[r], ip_cyc[r], r, 8 + 2 * r); end
         n_assert++; if (ip_in[r] !== row_pat(4 + r) || ip_ps[r] !== row_pat(8 + r)) begin
            n_fail++; $display("FAIL wl_ipdata%0d: got %0h/%0h, expected %0h/%0h",
                               r, ip_in[r], ip_ps[r], row_pat(4 + r), row_pat(8 + r)); end
      end
      n_assert++; if (ren_cnt != 12) begin n_fail++; $display("FAIL wl_rencount: got %0d, expected 12", ren_cnt); end
      n_assert++; if (zero_err + overlap_err + pair_err != 0) begin
         n_fail++; $display("FAIL wl_idle_zero: got %0d/%0d/%0d, expected 0/0/0", zero_err, overlap_err, pair_err); end
      n_assert++; if (job_ready !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL wl_end_status: got ready %b busy %b, expected 1 1", job_ready, busy); end
   endtask

   task automatic test_drain_wait();
      bit ok;
      int rens;
      do_reset(); drained = 0; fifo_has_space = 1;
      submit(1'b1, 10'd0, ok);
      rens = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (sp_ren) rens++; end
      n_assert++; if (rens != 0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL dw_hold: got %0d reads busy %b, expected 0 reads busy 1", rens, busy); end
      drained = 1;
      collect(40);
      n_assert++; if (first_ren != 1 || w_cnt != 4 || w_cyc[0] != 3) begin
         n_fail++; $display("FAIL dw_timing: got ren %0d count %0d cyc %0d, expected 1 4 3", first_ren, w_cnt, w_cyc[0]); end
      for (int r = 0; r < 4; r++) begin
         n_assert++; if (w_row[r] !== 2'(r) || w_dat[r] !== row_pat(r)) begin
            n_fail++; $display("FAIL dw_wrow%0d: got %0d %0h, expected %0d %0h", r, w_row[r], w_dat[r], r, row_pat(r)); end
      end
      n_assert++; if (ip_cnt != 4 || !done_seen) begin n_fail++; $display("FAIL dw_ipcount: got %0d, expected 4", ip_cnt); end
   endtask

   task automatic test_no_wload();
      bit ok;
      int rens;
      do_reset(); drained = 0; fifo_has_space = 0;
      submit(1'b0, 10'd16, ok);
      rens = 0;
      for (int i = 0; i < 5; i++) begin @(negedge clk); if (sp_ren) rens++; end
      n_assert++; if (rens != 0) begin n_fail++; $display("FAIL nw_hold: got %0d, expected 0", rens); end
      fifo_has_space = 1;
      collect(40);
      n_assert++; if (w_cnt != 0 || ip_cnt != 4 || ren_cnt != 8) begin
         n_fail++; $display("FAIL nw_counts: got w %0d ip %0d ren %0d, expected 0 4 8", w_cnt, ip_cnt, ren_cnt); end
      n_assert++; if (first_ren != 1 || ren_addr[1] !== 10'd20 || ren_addr[2] !== 10'd24) begin
         n_fail++; $display("FAIL nw_addr: got %0d %0d at %0d, expected 20 24 at 1", ren_addr[1], ren_addr[2], first_ren); end
      for (int r = 0; r < 4; r++) begin
         n_assert++; if (ip_in[r] !== row_pat(20 + r) || ip_ps[r] !== row_pat(24 + r) || ip_cyc[r] != 4 + 2 * r) begin
            n_fail++; $display("FAIL nw_row%0d: got %0h/%0h cyc %0d, expected %0h/%0h cyc %0d",
                               r, ip_in[r], ip_ps[r], ip_cyc[r], row_pat(20 + r), row_pat(24 + r), 4 + 2 * r); end
      end
   endtask

   task automatic test_tracker();
      bit ok;
      int acc, seen, pulses;
      do_reset(); drained = 0; fifo_has_space = 1;
      acc = 0;
      for (int j = 0; j < 4; j++) begin submit(1'b0, 10'd0, ok); if (ok) acc++; collect(40); end
      n_assert++; if (acc != 4 || job_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL tr_full: got acc %0d ready %b busy %b, expected 4 0 1", acc, job_ready, busy); end
      job_valid = 1; job_wload = 0; job_base = '0; seen = 0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (job_ready) seen++; end
      n_assert++; if (seen != 0) begin n_fail++; $display("FAIL tr_holdoff: got %0d, expected 0", seen); end
      out_en = 1; row_out = 2'd2;
      @(negedge clk);
      n_assert++; if (job_done !== 1'b0) begin n_fail++; $display("FAIL tr_row2_done: got %b, expected 0", job_done); end
      row_out = 2'd3;
      @(negedge clk);
      out_en = 0;
      n_assert++; if (job_done !== 1'b1 || job_ready !== 1'b1) begin
         n_fail++; $display("FAIL tr_complete: got done %b ready %b, expected 1 1", job_done, job_ready); end
      @(negedge clk);
      job_valid = 0;
      n_assert++; if (job_done !== 1'b0 || job_ready !== 1'b0) begin
         n_fail++; $display("FAIL tr_held_accept: got done %b ready %b, expected 0 0", job_done, job_ready); end
      collect(40);
      n_assert++; if (!done_seen || job_ready !== 1'b0) begin
         n_fail++; $display("FAIL tr_refull: got done %b ready %b, expected 1 0", done_seen, job_ready); end
      out_en = 1; row_out = 2'd3;
      @(negedge clk);
      job_valid = 1; out_en = 1;
      @(negedge clk);
      job_valid = 0; out_en = 0;
      n_assert++; if (job_done !== 1'b1 || job_ready !== 1'b0) begin
         n_fail++; $display("FAIL tr_simul: got done %b ready %b, expected 1 0", job_done, job_ready); end
      collect(40);
      submit(1'b0, 10'd0, ok);
      collect(40);
      n_assert++; if (!ok || job_ready !== 1'b0) begin
         n_fail++; $display("FAIL tr_count_kept: got accept %b ready %b, expected 1 0", ok, job_ready); end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         out_en = 1; row_out = 2'd3;
         @(negedge clk);
         out_en = 0;
         if (job_done) pulses++;
         @(negedge clk);
      end
      n_assert++; if (pulses != 4 || busy !== 1'b0) begin
         n_fail++; $display("FAIL tr_drain: got pulses %0d busy %b, expected 4 0", pulses, busy); end
   endtask

   task automatic test_reset_mid();
      bit ok, found;
      int extra;
      do_reset(); drained = 1; fifo_has_space = 1;
      submit(1'b1, 10'd0, ok);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (input_en && row_in_en == 2'd2) found = 1;
      end
      n_assert++; if (!found) begin n_fail++; $display("FAIL rm_row2: got 0, expected 1"); end
      nRST = 1'b0; #1;
      n_assert++; if ({sp_ren, weight_en, input_en, partial_en, busy, job_ready, job_done} !== 7'd0) begin
         n_fail++; $display("FAIL rm_flags: got %b, expected 0000000", {sp_ren, weight_en, input_en, partial_en, busy, job_ready, job_done}); end
      n_assert++; if ({sp_addr, row_in_en, row_ps_en} !== '0 || array_in !== '0 || array_in_partials !== '0) begin
         n_fail++; $display("FAIL rm_data: got in %0h ps %0h, expected 0", array_in, array_in_partials); end
      repeat (2) @(negedge clk);
      nRST = 1'b1; extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sp_ren || weight_en || input_en || partial_en) extra++;
      end
      n_assert++; if (extra != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rm_after: got %0d strobes busy %b, expected 0 0", extra, busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_weight_load();
      test_drain_wait();
      test_no_wload();
      test_tracker();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
